// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch program-counter generator.
//   pc_state_t          : BOOT / RUN / HALT states of the PC generator
//   DEFAULT_ADDR_WIDTH  : default PC / address width
//   step_log2()         : log2 of the PC step, used to size the alignment mask
package if_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;

  // Number of low address bits that must be zero for a STEP-aligned address.
  function automatic int unsigned step_log2(input int unsigned step);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < step) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Parametrised PC incrementer.
//   current_address : PC to advance
//   next_address    : current_address + STEP, wrapping modulo 2^ADDR_WIDTH
module pc_incr #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STEP       = 1
) (
  input  logic [ADDR_WIDTH-1:0] current_address,
  output logic [ADDR_WIDTH-1:0] next_address
);

  // The carry out of the top bit is dropped, so all-ones wraps to zero.
  assign next_address = current_address + ADDR_WIDTH'(STEP);

endmodule

// File: rtl/if_pc_gen.sv
// Registered program-counter generator for the IF stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : hold the PC and withdraw the fetch request
//   redirect_valid/addr : branch/jump target load (ignored if misaligned)
//   halt_req            : stop issuing after the current accepted fetch
//   pc_ready            : instruction memory accepts current_address
//   current_address     : registered PC presented to memory
//   next_address        : current_address + STEP (combinational)
//   pc_valid            : current_address is a valid fetch request
//   redirect_misaligned : one-cycle pulse after a rejected redirect
//   halted              : generator is in HALT
module if_pc_gen
  import if_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           STEP       = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  halt_req,
  input  logic                  pc_ready,
  output logic [ADDR_WIDTH-1:0] current_address,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic                  pc_valid,
  output logic                  redirect_misaligned,
  output logic                  halted
);

  localparam int unsigned           ALIGN_BITS = step_log2(STEP);
  // Low ALIGN_BITS set; all-zero for STEP=1 so no redirect is ever misaligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  pc_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  mis_q;

  logic misaligned;
  logic redirect_ok;
  logic accept;

  pc_incr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP       (STEP)
  ) u_pc_incr (
    .current_address (pc_q),
    .next_address    (next_address)
  );

  assign misaligned  = |(redirect_addr & ALIGN_MASK);
  assign redirect_ok = redirect_valid && !misaligned;
  assign accept      = pc_valid && pc_ready;

  assign current_address     = pc_q;
  assign pc_valid            = (state_q == RUN) && !stall;
  assign halted              = (state_q == HALT);
  assign redirect_misaligned = mis_q;

  // Priority mux: redirect beats halt, halt beats stall, stall beats advance.
  always_comb begin
    // NOTE: defaults first so every path assigns state_d/pc_d and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      BOOT: begin
        // BOOT lasts exactly one cycle; a redirect arriving now is still taken.
        if (redirect_ok) pc_d = redirect_addr;
        state_d = RUN;
      end
      RUN: begin
        if (redirect_ok) begin
          pc_d = redirect_addr;
        end else if (halt_req) begin
          if (accept) pc_d = next_address;
          state_d = HALT;
        end else if (!stall && accept) begin
          pc_d = next_address;
        end
      end
      HALT: begin
        if (redirect_ok) begin
          pc_d    = redirect_addr;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= redirect_valid && misaligned;
    end
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: three instances share one stimulus stream
//   u0: STEP=1, RESET_ADDR=0
//   u1: STEP=4, RESET_ADDR=0
//   u2: STEP=1, RESET_ADDR=32'hFFFF_FFFF
// A behavioural model per instance is compared every cycle; literal
// expectations from hand calculation pin the model.
module tb_if_pc_gen;

  localparam int N = 3;

  logic clk;
  logic rst_n;
  logic stall;
  logic redirect_valid;
  logic [31:0] redirect_addr;
  logic halt_req;
  logic pc_ready;

  logic [31:0] ca [N];
  logic [31:0] na [N];
  logic        pv [N];
  logic        mis [N];
  logic        hlt [N];

  int checks = 0;
  int errors = 0;

  if_pc_gen #(.ADDR_WIDTH(32), .STEP(1), .RESET_ADDR(32'h0)) u0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .halt_req(halt_req), .pc_ready(pc_ready),
    .current_address(ca[0]), .next_address(na[0]), .pc_valid(pv[0]),
    .redirect_misaligned(mis[0]), .halted(hlt[0]));

  if_pc_gen #(.ADDR_WIDTH(32), .STEP(4), .RESET_ADDR(32'h0)) u1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .halt_req(halt_req), .pc_ready(pc_ready),
    .current_address(ca[1]), .next_address(na[1]), .pc_valid(pv[1]),
    .redirect_misaligned(mis[1]), .halted(hlt[1]));

  if_pc_gen #(.ADDR_WIDTH(32), .STEP(1), .RESET_ADDR(32'hFFFF_FFFF)) u2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .halt_req(halt_req), .pc_ready(pc_ready),
    .current_address(ca[2]), .next_address(na[2]), .pc_valid(pv[2]),
    .redirect_misaligned(mis[2]), .halted(hlt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = booting, 1 = running, 2 = halted
  int unsigned m_step [N] = '{1, 4, 1};
  logic [31:0] m_rst  [N] = '{32'h0, 32'h0, 32'hFFFF_FFFF};
  logic [31:0] m_pc   [N] = '{32'h0, 32'h0, 32'hFFFF_FFFF};
  int          m_mode [N] = '{0, 0, 0};
  logic        m_mis  [N] = '{1'b0, 1'b0, 1'b0};

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pc[i]   = m_rst[i];
      m_mode[i] = 0;
      m_mis[i]  = 1'b0;
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        logic aligned;
        logic take;
        logic fetch_ok;
        aligned  = (redirect_addr % m_step[i]) == 0;
        take     = redirect_valid && aligned;
        fetch_ok = (m_mode[i] == 1) && !stall && pc_ready;
        m_mis[i] = redirect_valid && !aligned;
        if (m_mode[i] == 0) begin
          if (take) m_pc[i] = redirect_addr;
          m_mode[i] = 1;
        end else if (m_mode[i] == 2) begin
          if (take) begin
            m_pc[i]   = redirect_addr;
            m_mode[i] = 1;
          end
        end else if (take) begin
          m_pc[i] = redirect_addr;
        end else if (halt_req) begin
          if (fetch_ok) m_pc[i] = m_pc[i] + m_step[i];
          m_mode[i] = 2;
        end else if (fetch_ok) begin
          m_pc[i] = m_pc[i] + m_step[i];
        end
      end
    end
  end

  // One compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [31:0] exp_next;
      exp_next = m_pc[i] + m_step[i];
      check($sformatf("u%0d current_address", i), ca[i], m_pc[i]);
      check($sformatf("u%0d next_address", i), na[i], exp_next);
      check($sformatf("u%0d pc_valid", i), 32'(pv[i]), 32'((m_mode[i] == 1) && !stall));
      check($sformatf("u%0d halted", i), 32'(hlt[i]), 32'(m_mode[i] == 2));
      check($sformatf("u%0d redirect_misaligned", i), 32'(mis[i]), 32'(m_mis[i]));
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] ra;
    logic        halt;
    logic        ready;
  } vec_t;

  vec_t vecs [12] = '{
    '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1},  // advance
    '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0},  // backpressure hold
    '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1},  // stall hold
    '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0},  // halt without accept
    '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1},  // halt_req ignored in HALT
    '{1'b0, 1'b1, 32'h22, 1'b0, 1'b0},  // exits HALT for STEP=1 only
    '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1},  // advance
    '{1'b1, 1'b1, 32'h30, 1'b0, 1'b1},  // redirect over stall
    '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1},  // halt while stalled
    '{1'b0, 1'b1, 32'h03, 1'b0, 1'b1},  // misaligned for STEP=4
    '{1'b0, 1'b1, 32'h10, 1'b0, 1'b1},  // aligned everywhere
    '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1}   // advance
  };

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    halt_req       = 1'b0;
    pc_ready       = 1'b1;

    // 1. reset / boot
    repeat (3) cyc();
    check("reset pc u0", ca[0], 32'h0);
    check("reset pc u2", ca[2], 32'hFFFF_FFFF);
    check("reset valid u0", 32'(pv[0]), 32'h0);
    check("reset halted u0", 32'(hlt[0]), 32'h0);
    rst_n = 1'b1;
    #1 check("boot valid u0", 32'(pv[0]), 32'h0);
    cyc(); #1;
    check("run pc0 u0", ca[0], 32'h0);
    check("run valid u0", 32'(pv[0]), 32'h1);
    check("run next u0", na[0], 32'h1);
    check("wrap start u2", ca[2], 32'hFFFF_FFFF);
    cyc(); #1;
    check("run pc1 u0", ca[0], 32'h1);
    check("step4 pc u1", ca[1], 32'h4);
    check("wrap u2", ca[2], 32'h0);
    cyc(); #1 check("run pc2 u0", ca[0], 32'h2);
    cyc(); #1 check("run pc3 u0", ca[0], 32'h3);
    cyc();
    cyc(); #1 check("pc5 u0", ca[0], 32'h5);

    // 2. backpressure then stall
    pc_ready = 1'b0;
    repeat (3) begin
      cyc(); #1;
      check("bp hold u0", ca[0], 32'h5);
      check("bp valid u0", 32'(pv[0]), 32'h1);
    end
    pc_ready = 1'b1;
    stall    = 1'b1;
    repeat (2) begin
      cyc(); #1;
      check("stall hold u0", ca[0], 32'h5);
      check("stall valid u0", 32'(pv[0]), 32'h0);
    end
    stall = 1'b0;
    cyc(); #1 check("release u0", ca[0], 32'h6);

    // 3. redirect beats halt, then halt with accept
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    halt_req       = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("redir pc u0", ca[0], 32'h100);
    check("redir halted u0", 32'(hlt[0]), 32'h0);
    cyc();
    halt_req = 1'b0;
    #1;
    check("halt pc u0", ca[0], 32'h101);
    check("halt halted u0", 32'(hlt[0]), 32'h1);
    check("halt pc u1", ca[1], 32'h104);

    // 4. exit HALT by redirect
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    pc_ready       = 1'b0;
    #1;
    check("exit pc u0", ca[0], 32'h40);
    check("exit halted u0", 32'(hlt[0]), 32'h0);
    check("exit valid u0", 32'(pv[0]), 32'h1);

    // 5. misaligned redirect on the STEP=4 instance
    redirect_valid = 1'b1;
    redirect_addr  = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("mis pc u1", ca[1], 32'h40);
    check("mis pulse u1", 32'(mis[1]), 32'h1);
    check("aligned pc u0", ca[0], 32'h102);
    check("no pulse u0", 32'(mis[0]), 32'h0);
    cyc(); #1;
    check("mis clear u1", 32'(mis[1]), 32'h0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h104;
    cyc();
    redirect_valid = 1'b0;
    pc_ready       = 1'b1;
    #1 check("align pc u1", ca[1], 32'h104);
    cyc(); #1 check("align adv u1", ca[1], 32'h108);

    // 6. asynchronous reset mid-cycle
    #1 rst_n = 1'b0;
    #1;
    check("async pc u2", ca[2], 32'hFFFF_FFFF);
    check("async valid u2", 32'(pv[2]), 32'h0);
    check("async pc u0", ca[0], 32'h0);
    cyc();
    cyc();
    // redirect presented during BOOT is latched
    rst_n          = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    #1 check("boot redir u0", ca[0], 32'h80);

    // mixed directed vectors, checked by the model
    for (int v = 0; v < 12; v++) begin
      stall          = vecs[v].stall;
      redirect_valid = vecs[v].rv;
      redirect_addr  = vecs[v].ra;
      halt_req       = vecs[v].halt;
      pc_ready       = vecs[v].ready;
      cyc();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
Parametrised program-counter generator for the IF stage. It supersedes the fixed combinational incrementer with a registered PC and a configurable step, which defaults to 1 for word addressing. It adds a valid/ready issue handshake toward instruction memory, plus branch/jump redirect, stall, and halt control. The block sits between the EX/branch-resolution feedback path and the instruction-memory address port.

Parameters:
ADDR_WIDTH, 32, width of the PC and all address ports.
STEP, 1, increment per issued fetch; must be a power of two ≥1 (1 = word addressing).
RESET_ADDR, 0, PC value loaded on reset; must be STEP-aligned.

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hold PC; suppresses advance, does not block redirect.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_addr  input  ADDR_WIDTH  redirect target.
halt_req  input  1  stop issuing after the current accepted fetch.
pc_ready  input  1  instruction memory accepts current_address.
current_address  output  ADDR_WIDTH  registered PC presented to memory.
next_address  output  ADDR_WIDTH  combinational current_address + STEP, modulo 2^ADDR_WIDTH.
pc_valid  output  1  current_address is a valid fetch request.
redirect_misaligned  output  1  one-cycle pulse: rejected misaligned redirect.
halted  output  1  block is in HALT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - current_address=RESET_ADDR, pc_valid=0, redirect_misaligned=0, halted=0, state=BOOT.
- States are BOOT, RUN, and HALT.
  - BOOT: exactly one cycle after rst_n deasserts, then → RUN. pc_valid=0 in BOOT.
  - RUN: pc_valid=1 unless stall=1; the PC is held while stall=1.
  - HALT: pc_valid=0, halted=1. The PC is frozen; only an aligned redirect exits HALT.
- Accept: a fetch is accepted in a cycle with pc_valid=1 and pc_ready=1.
- Per-cycle priority in RUN, evaluated at the rising edge:
  1. Aligned redirect: current_address←redirect_addr. Any unaccepted request is dropped. The state stays RUN, even if halt_req=1 in the same cycle; halt_req must be re-asserted.
  2. Else if halt_req=1 and an accept occurs: current_address←next_address, then → HALT.
  3. Else if halt_req=1 with no accept: the PC is held, then → HALT. The request is withdrawn.
  4. Else if stall=1: hold.
  5. Else if accept: current_address←next_address.
  6. Else: hold. current_address must stay stable while pc_valid=1 and pc_ready=0.
- Redirect in HALT: an aligned redirect loads current_address and → RUN; pc_valid=1 on the following cycle. halt_req is ignored while in HALT.
- Redirect in BOOT: it is latched into current_address; BOOT still lasts its single cycle.
- Alignment: a redirect is misaligned when the low log2(STEP) bits of redirect_addr are nonzero (never, for STEP=1).
  - A misaligned redirect is ignored (PC unchanged, state unchanged).
  - redirect_misaligned pulses high for the next cycle only.
- Wrap-around: the increment wraps modulo 2^ADDR_WIDTH with no flag; e.g. all-ones with STEP=1 → 0.
- Latency:
  - Redirect to new current_address: 1 cycle.
  - Accept to incremented PC: 1 cycle.
  - next_address: 0 cycles (combinational).
- Reset mid-operation: outputs return to their reset values immediately (asynchronously); pending state is discarded.

Decomposition:
- Shared package if_pkg holds:
  - the pc_state_t enum {BOOT, RUN, HALT};
  - a default ADDR_WIDTH constant;
  - a function returning log2(STEP) for the alignment mask.
- One natural sub-module: pc_incr, a combinational parametrised adder with output next_address = current_address + STEP. It is the generalised incrementer and is testable on its own.
- The state register, PC register, and priority mux stay in if_pc_gen.

Test Plan:
1. Reset/boot: rst_n=0→1, pc_ready=1 → pc_valid=0 for 1 cycle; then current_address 0, 1, 2, 3 on consecutive cycles; next_address always equals current_address+1.
2. Backpressure/stall: pc_ready=0 for 3 cycles at PC=5 → current_address holds 5, pc_valid=1. Then stall=1 for 2 cycles → pc_valid=0, PC=5. On release, PC advances to 6.
3. Redirect vs halt: redirect_valid=1, redirect_addr=0x100, halt_req=1, same cycle → PC=0x100, state RUN, halted=0. Next cycle, halt_req=1 with an accept → PC=0x101, halted=1.
4. Halt exit: in HALT, redirect to 0x40 → next cycle PC=0x40, halted=0, pc_valid=1.
5. Misalignment with STEP=4: redirect_addr=0x102 → PC unchanged, redirect_misaligned=1 for exactly 1 cycle. redirect_addr=0x104 → PC=0x104, then 0x108 after an accept.
6. Wrap and async reset: RESET_ADDR=0xFFFFFFFF (STEP=1) and an accept → PC=0x00000000. Asserting rst_n low mid-cycle → current_address=RESET_ADDR and pc_valid=0 before the next clock edge.
